// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial WIDTH-bit unsigned subtractor (a - b - bin), LSB first, one cell.
// Optional build macro SERIAL_SUB_CLAMP_EN saturates diff to zero when the final borrow is set.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_r;
  logic             br;
  logic             borrow_r;
  logic [CNT_W-1:0] count;
  logic             cell_d;
  logic             cell_nb;
  logic             last_bit;
  logic             load;
  logic             shift_en;

  // The single full-subtractor cell, fed by the shift-register LSBs and the borrow register.
  always_comb begin : full_subtractor
    cell_d  = a_sr[0] ^ b_sr[0] ^ br;
    cell_nb = (~a_sr[0] & (b_sr[0] | br)) | (b_sr[0] & br);
  end

  assign last_bit = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Count is reloaded on every accept, so its wrap after the last bit is harmless.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      diff_r   <= '0;
      br       <= 1'b0;
      borrow_r <= 1'b0;
      count    <= '0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      br    <= bin;
      count <= '0;
    end else if (shift_en) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      br     <= cell_nb;
      count  <= count + CNT_W'(1);
      diff_r <= {cell_d, diff_r[WIDTH-1:1]};
      if (last_bit) begin
        borrow_r <= cell_nb;
`ifdef SERIAL_SUB_CLAMP_EN
        if (cell_nb) begin
          diff_r <= '0;
        end
`endif
      end
    end
  end

  assign diff       = diff_r;
  assign borrow_out = borrow_r;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: scoreboard bench for serial_subtractor_ctrl at WIDTH=8.
// Honours SERIAL_SUB_CLAMP_EN the same way the design does.
module tb_serial_subtractor_ctrl;

  localparam int WIDTH    = 8;
  localparam int MAX_WAIT = 200;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
  } result_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  result_t sb[$];
  int      vectors     = 0;
  int      miscompares = 0;
  int      handshakes  = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow_out(borrow_out)
  );

  function automatic result_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                    input logic mbin);
    logic [WIDTH:0] full;
    result_t        r;
    full     = {1'b0, ma} - {1'b0, mb} - {{WIDTH{1'b0}}, mbin};
    r.diff   = full[WIDTH-1:0];
    r.borrow = full[WIDTH];
`ifdef SERIAL_SUB_CLAMP_EN
    if (r.borrow) r.diff = '0;
`endif
    return r;
  endfunction

  // Inputs change only 1ns after a rising edge, so a handshake seen here completes at the next edge.
  always @(negedge clk) begin
    result_t exp_r;
    if (rst_n && out_valid && out_ready) begin
      handshakes++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_result: got diff=%h borrow=%b, required no result", diff, borrow_out);
      end else begin
        exp_r = sb.pop_front();
        if ({diff, borrow_out} !== exp_r) begin
          miscompares++;
          $display("[TB] FAIL scoreboard: got diff=%h borrow=%b, required diff=%h borrow=%b",
                   diff, borrow_out, exp_r.diff, exp_r.borrow);
        end
      end
    end
  end

  task automatic drive_pair(input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb,
                            input logic pbin, input bit expect_result);
    int n = 0;
    while (!in_ready && n < MAX_WAIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    a        = pa;
    b        = pb;
    bin      = pbin;
    in_valid = 1'b1;
    if (expect_result) sb.push_back(model(pa, pb, pbin));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < MAX_WAIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL out_valid_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
    end
  endtask

  task automatic wait_drained();
    int n = 0;
    while (!(in_ready && sb.size() == 0) && n < MAX_WAIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(in_ready && sb.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: in_ready=%b pending=%0d, required 1 and 0", in_ready, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vectors += 4;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready); end
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (diff !== '0) begin miscompares++; $display("[TB] FAIL reset_diff: got %h, required 00", diff); end
    if (borrow_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_borrow: got %b, required 0", borrow_out); end
  endtask

  // out_ready is held high throughout, so it must not shorten the SHIFT phase.
  task automatic test_basic();
    out_ready = 1'b1;
    drive_pair(8'h5A, 8'h23, 1'b0, 1'b1);
    for (int k = 0; k <= WIDTH; k++) begin
      vectors++;
      if (out_valid !== 1'(k == WIDTH)) begin
        miscompares++;
        $display("[TB] FAIL latency_out_valid: cycle %0d got %b, required %b", k, out_valid, (k == WIDTH));
      end
      if (k < WIDTH) begin
        @(posedge clk); #1;
      end
    end
    vectors += 3;
    if (diff !== 8'h37) begin miscompares++; $display("[TB] FAIL basic_diff: got %h, required 37", diff); end
    if (borrow_out !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_borrow: got %b, required 0", borrow_out); end
    if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_in_ready_done: got %b, required 0", in_ready); end
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_return_idle: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_borrow();
    logic [WIDTH-1:0] want;
`ifdef SERIAL_SUB_CLAMP_EN
    want = 8'h00;
`else
    want = 8'hF0;
`endif
    out_ready = 1'b1;
    drive_pair(8'h10, 8'h20, 1'b0, 1'b1);
    wait_out_valid();
    vectors += 2;
    if (diff !== want) begin miscompares++; $display("[TB] FAIL borrow_diff: got %h, required %h", diff, want); end
    if (borrow_out !== 1'b1) begin miscompares++; $display("[TB] FAIL borrow_flag: got %b, required 1", borrow_out); end
    wait_drained();
  endtask

  task automatic test_zero();
    logic [WIDTH-1:0] want;
`ifdef SERIAL_SUB_CLAMP_EN
    want = 8'h00;
`else
    want = 8'hFF;
`endif
    out_ready = 1'b1;
    drive_pair(8'h00, 8'h00, 1'b1, 1'b1);
    wait_out_valid();
    vectors += 2;
    if (diff !== want) begin miscompares++; $display("[TB] FAIL zero_bin1_diff: got %h, required %h", diff, want); end
    if (borrow_out !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_bin1_borrow: got %b, required 1", borrow_out); end
    wait_drained();
    drive_pair(8'h00, 8'h00, 1'b0, 1'b1);
    wait_out_valid();
    vectors += 2;
    if (diff !== 8'h00) begin miscompares++; $display("[TB] FAIL zero_bin0_diff: got %h, required 00", diff); end
    if (borrow_out !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_bin0_borrow: got %b, required 0", borrow_out); end
    wait_drained();
  endtask

  task automatic test_backpressure();
    result_t          want;
    logic [WIDTH-1:0] held_d;
    logic             held_b;
    want      = model(8'h33, 8'h44, 1'b1);
    out_ready = 1'b0;
    drive_pair(8'h33, 8'h44, 1'b1, 1'b1);
    wait_out_valid();
    held_d = diff;
    held_b = borrow_out;
    vectors++;
    if ({held_d, held_b} !== want) begin
      miscompares++;
      $display("[TB] FAIL stall_value: got diff=%h borrow=%b, required diff=%h borrow=%b",
               held_d, held_b, want.diff, want.borrow);
    end
    repeat (5) begin
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || diff !== held_d || borrow_out !== held_b || in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_hold: got out_valid=%b diff=%h borrow=%b in_ready=%b, required 1 %h %b 0",
                 out_valid, diff, borrow_out, in_ready, held_d, held_b);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive_pair(8'hAA, 8'h11, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors += 4;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_in_ready: got %b, required 1", in_ready); end
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_out_valid: got %b, required 0", out_valid); end
    if (diff !== '0) begin miscompares++; $display("[TB] FAIL midrst_diff: got %h, required 00", diff); end
    if (borrow_out !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_borrow: got %b, required 0", borrow_out); end
    drive_pair(8'h05, 8'h03, 1'b0, 1'b1);
    wait_out_valid();
    vectors++;
    if (diff !== 8'h02 || borrow_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_followup: got diff=%h borrow=%b, required 02 0", diff, borrow_out);
    end
    wait_drained();
  endtask

  // in_valid stays high with junk data during SHIFT/DONE, except a one-edge low pulse after each accept.
  task automatic test_back_to_back();
    logic [WIDTH-1:0] ta[4] = '{8'hFF, 8'h01, 8'h80, 8'h7F};
    logic [WIDTH-1:0] tb[4] = '{8'h01, 8'hFF, 8'h80, 8'h00};
    logic             tc[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    int               hs0;
    int               gap;
    hs0       = handshakes;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      gap = 0;
      while (!in_ready && gap < MAX_WAIT) begin
        @(posedge clk); #1;
        in_valid = 1'b1;
        gap++;
      end
      if (k > 0) begin
        vectors++;
        if (gap + 1 !== WIDTH + 2) begin
          miscompares++;
          $display("[TB] FAIL b2b_spacing: pair %0d got %0d cycles, required %0d", k, gap + 1, WIDTH + 2);
        end
      end
      a        = ta[k];
      b        = tb[k];
      bin      = tc[k];
      in_valid = 1'b1;
      sb.push_back(model(ta[k], tb[k], tc[k]));
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b_accept: pair %0d in_ready=%b after accept edge, required 0", k, in_ready);
      end
      in_valid = 1'b0;
      a        = ~ta[k];
      b        = ~tb[k];
      bin      = ~tc[k];
    end
    wait_drained();
    vectors++;
    if (handshakes - hs0 !== 4) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d results, required 4", handshakes - hs0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL leftover_results: got %0d pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
